if_stage: RTL

- Instruction-fetch stage of the 16-bit pipelined core.
- Owns the architectural PC register and drives the instruction-memory/I-cache request interface.
- Loads the IF/ID pipeline register.
- Consumes the next-PC and flush outputs of the PC control logic in decode as a redirect, and consumes the stall signal from the hazard unit.

---
 rtl/if_stage_if.sv | 11 +
 rtl/if_stage.sv | 110 +++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory / I-cache request bus between the fetch stage and memory.
`timescale 1ns/1ps
interface if_stage_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        imem_valid;

   modport master (output imem_req, output imem_addr, input imem_data, input imem_valid);
   modport slave  (input imem_req, input imem_addr, output imem_data, output imem_valid);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests,
// absorbs stalls and redirects, and loads the IF/ID pipeline register.
`timescale 1ns/1ps
module if_stage #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] NOP_INSTR   = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_en,
   input  logic [15:0]      redirect_pc,
   input  logic             stall,
   if_stage_if.master       imem,
   output logic [15:0]      ifid_instr,
   output logic [15:0]      ifid_pc_plus_two,
   output logic             ifid_valid,
   output logic [15:0]      pc,
   output logic             halted
);

   typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN, S_HALTED} state_t;

   state_t      state;
   logic [15:0] fetch_addr;
   logic [15:0] hold_buf;
   logic [15:0] next_addr;
   logic [15:0] deliver_instr;
   logic        deliver;
   logic        is_halt;
   logic        outstanding;

   // Pick the instruction being delivered: a held word after a stall, else the bus.
   always_comb begin
      // NOTE: give every always_comb output a default first so no latch is inferred.
      deliver_instr = imem.imem_data;
      if (state == S_HOLD) deliver_instr = hold_buf;
   end

   assign next_addr   = fetch_addr + 16'd2;
   assign is_halt     = (deliver_instr[15:12] == HALT_OPCODE);
   assign deliver     = !redirect_en && !stall &&
                        ((state == S_FETCH && imem.imem_valid) || state == S_HOLD);
   // A request is still in flight if the bus is being driven and no data came back.
   assign outstanding = (state == S_FETCH || state == S_DRAIN) && !imem.imem_valid;

   // Request goes low the instant reset is asserted, not at the next edge.
   assign imem.imem_req  = !rst && (state == S_FETCH || state == S_DRAIN);
   assign imem.imem_addr = fetch_addr;
   assign halted         = (state == S_HALTED);

   // Fetch state machine, PC, hold buffer and IF/ID register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state            <= S_FETCH;
         pc               <= RESET_PC;
         fetch_addr       <= RESET_PC;
         hold_buf         <= NOP_INSTR;
         ifid_instr       <= NOP_INSTR;
         ifid_pc_plus_two <= 16'h0000;
         ifid_valid       <= 1'b0;
      end else if (redirect_en) begin
         pc               <= redirect_pc;
         ifid_instr       <= NOP_INSTR;
         ifid_pc_plus_two <= 16'h0000;
         ifid_valid       <= 1'b0;
         if (outstanding) begin
            state <= S_DRAIN;
         end else begin
            state      <= S_FETCH;
            fetch_addr <= redirect_pc;
         end
      end else if (deliver) begin
         ifid_instr       <= deliver_instr;
         ifid_pc_plus_two <= next_addr;
         ifid_valid       <= 1'b1;
         if (is_halt) begin
            // pc stays at the halt address so a later redirect is the only exit.
            state <= S_HALTED;
         end else begin
            state      <= S_FETCH;
            pc         <= next_addr;
            fetch_addr <= next_addr;
         end
      end else begin
         case (state)
            S_FETCH: begin
               if (imem.imem_valid) begin
                  hold_buf <= imem.imem_data;
                  state    <= S_HOLD;
               end else if (!stall) begin
                  ifid_valid <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (imem.imem_valid) begin
                  fetch_addr <= pc;
                  state      <= S_FETCH;
               end
            end
            S_HALTED: begin
               if (!stall) ifid_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
